// File: rtl/washer_pkg.sv
// Shared level-state and band types plus default
// sensor thresholds for the washer sensor path.
package washer_pkg;

   typedef enum logic [1:0] {
      LS_UNKNOWN,
      LS_EMPTY,
      LS_MID,
      LS_FULL
   } lvl_state_t;

   typedef enum logic [1:0] {
      BAND_LOW,
      BAND_MID,
      BAND_HIGH
   } band_t;

   localparam int DEF_LEVEL_W        = 8;
   localparam int DEF_EMPTY_ON       = 10;
   localparam int DEF_EMPTY_OFF      = 25;
   localparam int DEF_FULL_OFF       = 180;
   localparam int DEF_FULL_ON        = 200;
   localparam int DEF_LVL_QUAL       = 3;
   localparam int DEF_DEB_CYCLES     = 4;
   localparam int DEF_SAMPLE_TIMEOUT = 64;

   function automatic lvl_state_t band_state(
      input band_t b
   );
      case (b)
         BAND_LOW:  return LS_EMPTY;
         BAND_HIGH: return LS_FULL;
         default:   return LS_MID;
      endcase
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Counter debounce for a single raw switch; the output
// flips after DEB_CYCLES consecutive disagreeing cycles.
module sensor_debounce #(
   parameter int   DEB_CYCLES = 4,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic raw,
   output logic deb
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt <= '0;
         deb <= RST_VAL;
      end else if (raw == deb) begin
         cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
         cnt <= '0;
         deb <= ~deb;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/washer_sensor_cond.sv
// Level band FSM with sample qualification, stall
// watchdog and debounced door/dry switches.
module washer_sensor_cond
   import washer_pkg::*;
#(
   parameter int LEVEL_W        = DEF_LEVEL_W,
   parameter int EMPTY_ON       = DEF_EMPTY_ON,
   parameter int EMPTY_OFF      = DEF_EMPTY_OFF,
   parameter int FULL_OFF       = DEF_FULL_OFF,
   parameter int FULL_ON        = DEF_FULL_ON,
   parameter int LVL_QUAL       = DEF_LVL_QUAL,
   parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
   parameter int SAMPLE_TIMEOUT = DEF_SAMPLE_TIMEOUT
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [LEVEL_W-1:0] level_raw,
   input  logic               level_valid,
   input  logic               door_raw,
   input  logic               dry_raw,
   input  logic               clear_fault,
   output logic               water_full,
   output logic               drained,
   output logic               door_open,
   output logic               dry_sensor,
   output logic               sensor_fault
);

   localparam int QW = $clog2(LVL_QUAL + 1);
   localparam int WW = $clog2(SAMPLE_TIMEOUT + 1);

   localparam logic [LEVEL_W-1:0] E_ON  = LEVEL_W'(EMPTY_ON);
   localparam logic [LEVEL_W-1:0] E_OFF = LEVEL_W'(EMPTY_OFF);
   localparam logic [LEVEL_W-1:0] F_OFF = LEVEL_W'(FULL_OFF);
   localparam logic [LEVEL_W-1:0] F_ON  = LEVEL_W'(FULL_ON);

   lvl_state_t    state, state_d;
   lvl_state_t    tgt, tgt_d;
   lvl_state_t    exit_tgt;
   band_t         band;
   logic          exit_hit;
   logic [QW-1:0] qcnt, qcnt_d, qn;
   logic [WW-1:0] wd, wd_d;
   logic          timeout;

   always_comb begin
      band = BAND_MID;
      if (level_raw <= E_ON)
         band = BAND_LOW;
      else if (level_raw >= F_ON)
         band = BAND_HIGH;
   end

   always_comb begin
      exit_hit = 1'b0;
      exit_tgt = state;
      unique case (state)
         LS_UNKNOWN: begin
            exit_hit = 1'b1;
            exit_tgt = band_state(band);
         end
         LS_EMPTY: begin
            if (level_raw > E_OFF) begin
               exit_hit = 1'b1;
               exit_tgt = LS_MID;
            end
         end
         LS_MID: begin
            if (band == BAND_LOW) begin
               exit_hit = 1'b1;
               exit_tgt = LS_EMPTY;
            end else if (band == BAND_HIGH) begin
               exit_hit = 1'b1;
               exit_tgt = LS_FULL;
            end
         end
         LS_FULL: begin
            if (level_raw < F_OFF) begin
               exit_hit = 1'b1;
               exit_tgt = LS_MID;
            end
         end
      endcase
   end

   always_comb begin
      wd_d = wd;
      if (level_valid)
         wd_d = '0;
      else if (wd != WW'(SAMPLE_TIMEOUT))
         wd_d = wd + WW'(1);
      timeout = (wd_d == WW'(SAMPLE_TIMEOUT));
   end

   // A target change restarts the run at 1, not 0.
   always_comb begin
      state_d = state;
      tgt_d   = tgt;
      qcnt_d  = qcnt;
      qn      = (tgt == exit_tgt) ? qcnt + QW'(1) : QW'(1);
      if (level_valid) begin
         if (exit_hit) begin
            tgt_d = exit_tgt;
            if (qn == QW'(LVL_QUAL)) begin
               state_d = exit_tgt;
               qcnt_d  = '0;
            end else begin
               qcnt_d = qn;
            end
         end else begin
            qcnt_d = '0;
         end
      end
      if (timeout) begin
         state_d = LS_UNKNOWN;
         qcnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= LS_UNKNOWN;
         tgt          <= LS_UNKNOWN;
         qcnt         <= '0;
         wd           <= '0;
         water_full   <= 1'b0;
         drained      <= 1'b0;
         sensor_fault <= 1'b0;
      end else begin
         state        <= state_d;
         tgt          <= tgt_d;
         qcnt         <= qcnt_d;
         wd           <= wd_d;
         water_full   <= (state_d == LS_FULL);
         drained      <= (state_d == LS_EMPTY);
         sensor_fault <= timeout |
                         (sensor_fault & ~clear_fault);
      end
   end

   sensor_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (1'b1)
   ) u_door (
      .clk  (clk),
      .rstn (rstn),
      .raw  (door_raw),
      .deb  (door_open)
   );

   sensor_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (1'b0)
   ) u_dry (
      .clk  (clk),
      .rstn (rstn),
      .raw  (dry_raw),
      .deb  (dry_sensor)
   );

endmodule

// File: tb/tb_washer_sensor_cond.sv
// Directed vector bench for washer_sensor_cond with
// hand-written watchdog sequences.
module tb_washer_sensor_cond;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] level_raw;
   logic       level_valid;
   logic       door_raw;
   logic       dry_raw;
   logic       clear_fault;
   logic       water_full;
   logic       drained;
   logic       door_open;
   logic       dry_sensor;
   logic       sensor_fault;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       r;
      logic       v;
      logic [7:0] l;
      logic       d;
      logic       y;
      logic       c;
      logic [4:0] e;
      string      n;
   } vec_t;

   vec_t tbl[$];

   washer_sensor_cond dut (
      .clk          (clk),
      .rstn         (rstn),
      .level_raw    (level_raw),
      .level_valid  (level_valid),
      .door_raw     (door_raw),
      .dry_raw      (dry_raw),
      .clear_fault  (clear_fault),
      .water_full   (water_full),
      .drained      (drained),
      .door_open    (door_open),
      .dry_sensor   (dry_sensor),
      .sensor_fault (sensor_fault)
   );

   always #5 clk = ~clk;

   // e = {water_full, drained, door_open, dry_sensor, sensor_fault}
   task automatic add(
      input logic r, v, input logic [7:0] l,
      input logic d, y, c, input logic [4:0] e,
      input string n
   );
      vec_t t;
      t.r = r; t.v = v; t.l = l;
      t.d = d; t.y = y; t.c = c;
      t.e = e; t.n = n;
      tbl.push_back(t);
   endtask

   task automatic step(
      input logic r, v, input logic [7:0] l,
      input logic d, y, c, input logic [4:0] e,
      input string n
   );
      logic [4:0] got;
      rstn        = r;
      level_valid = v;
      level_raw   = l;
      door_raw    = d;
      dry_raw     = y;
      clear_fault = c;
      @(posedge clk);
      #1;
      got = {water_full, drained, door_open,
             dry_sensor, sensor_fault};
      checks++;
      if (got !== e) begin
         failures++;
         $display("FAIL %s: got %b expected %b",
                  n, got, e);
      end
   endtask

   initial begin
      rstn        = 1'b0;
      level_valid = 1'b0;
      level_raw   = '0;
      door_raw    = 1'b1;
      dry_raw     = 1'b0;
      clear_fault = 1'b0;

      add(0,0,  0,1,0,0, 5'b00100, "reset");
      add(1,1,  5,1,0,0, 5'b00100, "drain_q1");
      add(1,1,  5,1,0,0, 5'b00100, "drain_q2");
      add(1,1,  5,1,0,0, 5'b01100, "drain_q3");
      add(1,1,  5,0,0,0, 5'b01100, "door_c1");
      add(1,1,  5,0,0,0, 5'b01100, "door_c2");
      add(1,1,  5,0,0,0, 5'b01100, "door_c3");
      add(1,1,  5,0,0,0, 5'b01000, "door_closed");
      add(1,1,  5,1,0,0, 5'b01000, "door_gl1");
      add(1,1,  5,1,0,0, 5'b01000, "door_gl2");
      add(1,1,  5,1,0,0, 5'b01000, "door_gl3");
      add(1,1,  5,0,0,0, 5'b01000, "door_gl_end");
      add(1,1,  5,1,0,0, 5'b01000, "door_o1");
      add(1,1,  5,1,0,0, 5'b01000, "door_o2");
      add(1,1,  5,1,0,0, 5'b01000, "door_o3");
      add(1,1,  5,1,0,0, 5'b01100, "door_open");
      add(1,1,  5,1,1,0, 5'b01100, "dry_gl1");
      add(1,1,  5,1,1,0, 5'b01100, "dry_gl2");
      add(1,1,  5,1,1,0, 5'b01100, "dry_gl3");
      add(1,1,  5,1,0,0, 5'b01100, "dry_gl_end");
      add(1,1,  5,1,1,0, 5'b01100, "dry_h1");
      add(1,1,  5,1,1,0, 5'b01100, "dry_h2");
      add(1,1,  5,1,1,0, 5'b01100, "dry_h3");
      add(1,1,  5,1,1,0, 5'b01110, "dry_set");
      add(1,1,  5,1,0,0, 5'b01110, "wet_h1");
      add(1,1,  5,1,0,0, 5'b01110, "wet_h2");
      add(1,1,  5,1,0,0, 5'b01110, "wet_h3");
      add(1,1,  5,1,0,0, 5'b01100, "wet_set");
      add(1,1, 30,1,0,0, 5'b01100, "ramp_m1");
      add(1,1, 30,1,0,0, 5'b01100, "ramp_m2");
      add(1,1, 30,1,0,0, 5'b00100, "ramp_mid");
      add(1,1,205,1,0,0, 5'b00100, "ramp_f1");
      add(1,1,205,1,0,0, 5'b00100, "ramp_f2");
      add(1,1,205,1,0,0, 5'b10100, "ramp_full");
      for (int i = 0; i < 5; i++)
         add(1,1,190,1,0,0, 5'b10100, "hyst_190");
      add(1,1,170,1,0,0, 5'b10100, "drop_1");
      add(1,1,170,1,0,0, 5'b10100, "drop_2");
      add(1,1,170,1,0,0, 5'b00100, "drop_mid");
      add(1,1,205,1,0,0, 5'b00100, "qr_205a");
      add(1,1,205,1,0,0, 5'b00100, "qr_205b");
      add(1,1,150,1,0,0, 5'b00100, "qr_150");
      add(1,1,205,1,0,0, 5'b00100, "qr_205c");
      add(1,0,  0,1,0,0, 5'b00100, "qr_gap1");
      add(1,1,205,1,0,0, 5'b00100, "qr_205d");
      add(1,0,  0,1,0,0, 5'b00100, "qr_gap2");
      add(1,1,205,1,0,0, 5'b10100, "qr_full");
      add(1,1,170,1,0,0, 5'b10100, "mr_p1");
      add(1,1,170,1,0,0, 5'b10100, "mr_p2");
      add(0,1,170,1,0,0, 5'b00100, "mr_reset");
      add(1,1,205,1,0,0, 5'b00100, "mr_q1");
      add(1,1,205,1,0,0, 5'b00100, "mr_q2");
      add(1,1,205,1,0,0, 5'b10100, "mr_full");

      @(posedge clk);
      #1;
      foreach (tbl[i])
         step(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].d,
              tbl[i].y, tbl[i].c, tbl[i].e, tbl[i].n);

      for (int i = 0; i < 63; i++)
         step(1,0,0,1,0,0, 5'b10100, "wd_pre");
      step(1,0,  0,1,0,0, 5'b00101, "wd_timeout");
      step(1,1,205,1,0,1, 5'b00100, "wd_clear");
      step(1,1,205,1,0,0, 5'b00100, "wd_rq2");
      step(1,1,205,1,0,0, 5'b10100, "wd_refull");

      for (int i = 0; i < 63; i++)
         step(1,0,0,1,0,0, 5'b10100, "wd2_pre");
      step(1,0,  0,1,0,1, 5'b00101, "clr_at_timeout");
      step(1,0,  0,1,0,1, 5'b00101, "clr_saturated");
      step(1,0,  0,1,0,0, 5'b00101, "fault_sticky");
      step(1,1,  5,1,0,0, 5'b00101, "fault_q1");
      step(1,1,  5,1,0,1, 5'b00100, "fault_clr_q2");
      step(1,1,  5,1,0,0, 5'b01100, "fault_q3_drn");

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/washer_sensor_cond.md
Name: washer_sensor_cond

Overview:
Conditions raw machine sensors into the clean, registered status flags the washer control FSM consumes: water_full, drained, door_open, dry_sensor.
- Water level: an 8-bit sampled value is qualified over consecutive samples and passed through a hysteretic band state machine.
- Door switch and dryness contact: debounced.
- Level-sample source: watched for stalls, which raise a sticky sensor_fault.
- Sits directly upstream of the washer controller, between the sensor front-end and the control FSM.

Parameters:
- LEVEL_W, 8: width of the level sample.
- EMPTY_ON, 10: level <= this counts as the empty band.
- EMPTY_OFF, 25: level > this leaves the empty state.
- FULL_OFF, 180: level < this leaves the full state.
- FULL_ON, 200: level >= this counts as the full band.
- LVL_QUAL, 3: consecutive qualifying valid samples needed for a level-state change (>= 1).
- DEB_CYCLES, 4: consecutive cycles a raw switch must differ from its output before the output flips (>= 1).
- SAMPLE_TIMEOUT, 64: cycles without level_valid before sensor_fault sets.
- Legal ordering: EMPTY_ON < EMPTY_OFF < FULL_OFF < FULL_ON, all < 2^LEVEL_W.

Ports:
- clk  in  1  system clock, single clock domain.
- rstn  in  1  synchronous active-low reset.
- level_raw  in  LEVEL_W  water level sample.
- level_valid  in  1  level_raw valid this cycle.
- door_raw  in  1  raw door switch, 1 = open.
- dry_raw  in  1  raw dryness contact, 1 = dry.
- clear_fault  in  1  single-cycle pulse that clears sensor_fault.
- water_full  out  1  registered, level state FULL.
- drained  out  1  registered, level state EMPTY.
- door_open  out  1  debounced door.
- dry_sensor  out  1  debounced dryness.
- sensor_fault  out  1  sticky level-sample stall flag.

Behaviour:
- Reset (rstn=0 sampled at posedge) values:
  - Level state UNKNOWN; water_full=0, drained=0.
  - door_open=1 (fail-safe), dry_sensor=0, sensor_fault=0.
  - All counters 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Band classification of each valid sample: LOW if level <= EMPTY_ON; HIGH if level >= FULL_ON; else MID.
- Level FSM states: UNKNOWN, EMPTY, MID, FULL.
- Exit conditions per state:
  - UNKNOWN: target = sample's band; LOW -> EMPTY, MID -> MID, HIGH -> FULL.
  - EMPTY: level > EMPTY_OFF -> MID.
  - MID: level <= EMPTY_ON -> EMPTY; level >= FULL_ON -> FULL.
  - FULL: level < FULL_OFF -> MID.
- Qualification counter and target register:
  - Valid sample meeting an exit condition with the same target as the previous one: counter+1.
  - Valid sample meeting an exit condition with a different target: counter=1, target updated.
  - Valid sample meeting no exit condition: counter=0.
  - level_valid=0: counter holds.
- When the LVL_QUAL-th consecutive qualifying sample is seen in cycle N:
  - State changes at the end of cycle N; outputs are visible in cycle N+1.
  - Counter clears.
- Only one transition per qualification. EMPTY to FULL always passes through MID, so it needs 2*LVL_QUAL samples.
- Outputs: drained=1 only in EMPTY; water_full=1 only in FULL; both 0 in MID and UNKNOWN.
- Debounce, identical for door and dry:
  - Counter increments each cycle raw != output and clears on any cycle raw == output.
  - On the cycle the counter would reach DEB_CYCLES, the output flips and the counter clears.
  - A raw change held from cycle 0 is visible at the output in cycle DEB_CYCLES.
  - A glitch shorter than DEB_CYCLES has no effect.
- Stall watchdog:
  - Counter clears on level_valid=1, otherwise increments, saturating at SAMPLE_TIMEOUT.
  - When it reaches SAMPLE_TIMEOUT: sensor_fault<=1 and level FSM forced to UNKNOWN, so water_full=drained=0.
- Fault hold and clear:
  - While sensor_fault=1, valid samples are qualified from UNKNOWN as after reset.
  - clear_fault=1 clears sensor_fault only if the watchdog is below SAMPLE_TIMEOUT that cycle.
  - clear_fault coincident with timeout: the fault stays set.
- Reset mid-operation: all state returns to reset values on the next edge; partial qualifications and debounces are lost.

Decomposition:
- Package washer_pkg holds:
  - Level-state enum (UNKNOWN, EMPTY, MID, FULL) and band enum (LOW, MID, HIGH).
  - Default threshold constants shared with washer_ctrl benches.
- One sub-module, sensor_debounce (parameter DEB_CYCLES, reset value parameter RST_VAL), instantiated for door and dry.
- Level FSM, qualification counter and watchdog live in the top.

Test Plan (defaults):
- Reset, then level_valid=1 with level=5 for 3 cycles -> drained=1 in cycle 4; water_full=0; door_open=1 until door_raw=0 is held 4 cycles.
- Ramp from EMPTY: level=30 x3 then 205 x3 -> MID after 3rd sample, FULL after 6th; water_full=1, drained=0. Then 190 x5 -> stays FULL (hysteresis); 170 x3 -> MID.
- Qualification reset: in MID, samples 205, 205, 150, 205, 205 -> no FULL; 3rd consecutive 205 -> FULL. level_valid gaps between qualifying samples do not break qualification.
- Debounce: door_raw 0->1 for 3 cycles then back -> door_open unchanged; held 4 cycles -> door_open=1 in cycle 4. Same check on dry_raw.
- Watchdog: level_valid=0 for 64 cycles while FULL -> sensor_fault=1, water_full=0. clear_fault with valid samples resuming -> fault clears, re-qualification from UNKNOWN. clear_fault on the timeout cycle -> fault remains 1.
- Mid-qualification reset: rstn=0 after 2 of 3 qualifying samples -> all outputs at reset values; 3 new samples needed.
